// File: rtl/prbs_ber_ctrl.sv
// PRBS9 bit-error-rate controller: self-syncs to the incoming stream, then
// measures errors against a free-running local reference over a bit window.
module prbs_ber_ctrl #(
  parameter int CNT_W        = 32,
  parameter int SYNC_LEN     = 16,
  parameter int SYNC_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] window,
  input  logic             rx_bit,
  input  logic             rx_valid,
  output logic             tx_en,
  output logic             busy,
  output logic             locked,
  output logic             done,
  output logic             sync_fail,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_SYNC, S_MEAS, S_DONE} state_t;

  state_t           state, state_nx;
  logic [8:0]       hist, lfsr;
  logic [CNT_W-1:0] win;
  logic [7:0]       match_cnt;
  logic [15:0]      to_cnt;
  logic [3:0]       fill_cnt;

  logic             pred, lpred, sync_match, lock_hit, to_hit, meas_end, accept;
  logic [7:0]       match_inc;
  logic [15:0]      to_inc;
  logic [CNT_W-1:0] bit_inc;

  assign pred       = hist[8] ^ hist[4];
  assign lpred      = lfsr[8] ^ lfsr[4];
  // an all-zero history never counts as a match, so a dead line cannot lock
  assign sync_match = (rx_bit == pred) && (hist != 9'd0);
  assign match_inc  = match_cnt + 8'd1;
  assign to_inc     = to_cnt + 16'd1;
  assign bit_inc    = bit_count + 1'b1;
  assign lock_hit   = sync_match && (match_inc == 8'(SYNC_LEN));
  assign to_hit     = (to_inc == 16'(SYNC_TIMEOUT));
  assign meas_end   = (bit_inc == win);
  assign accept     = start && (window != '0) && (state == S_IDLE || state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (accept) state_nx = S_FILL;
      S_FILL: if (rx_valid && fill_cnt == 4'd8) state_nx = S_SYNC;
      S_SYNC: if (rx_valid) begin
        if (lock_hit)    state_nx = S_MEAS;
        else if (to_hit) state_nx = S_DONE;
      end
      S_MEAS: if (rx_valid && meas_end) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist      <= '0;
      lfsr      <= '0;
      win       <= '0;
      match_cnt <= '0;
      to_cnt    <= '0;
      fill_cnt  <= '0;
      bit_count <= '0;
      err_count <= '0;
      sync_fail <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (accept) begin
          win       <= window;
          bit_count <= '0;
          err_count <= '0;
          sync_fail <= 1'b0;
          match_cnt <= '0;
          to_cnt    <= '0;
          fill_cnt  <= '0;
        end
        S_FILL: if (rx_valid) begin
          hist     <= {hist[7:0], rx_bit};
          fill_cnt <= fill_cnt + 4'd1;
        end
        S_SYNC: if (rx_valid) begin
          hist      <= {hist[7:0], rx_bit};
          match_cnt <= sync_match ? match_inc : 8'd0;
          to_cnt    <= to_inc;
          if (lock_hit)    lfsr      <= {hist[7:0], rx_bit};
          else if (to_hit) sync_fail <= 1'b1;
        end
        S_MEAS: if (rx_valid) begin
          lfsr      <= {lfsr[7:0], lpred};
          bit_count <= bit_inc;
          if (rx_bit != lpred && err_count != '1) err_count <= err_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // status flags are registered from the next state so they track it with no input path
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy   <= 1'b0;
      tx_en  <= 1'b0;
      locked <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy   <= (state_nx == S_FILL) || (state_nx == S_SYNC) || (state_nx == S_MEAS);
      tx_en  <= (state_nx == S_FILL) || (state_nx == S_SYNC) || (state_nx == S_MEAS);
      locked <= (state_nx == S_MEAS);
      done   <= (state_nx == S_DONE);
    end
  end

endmodule
